// File: rtl/enter_conditioner_if.sv
// Button/switch bundle between the raw panel inputs and the conditioned outputs
// that feed main_FSM. The conditioner is the slave; whoever drives the raw
// inputs and consumes the pulse is the master.
interface enter_conditioner_if #(
  parameter int VAL_W = 4
);
  logic             enter_raw;
  logic [VAL_W-1:0] sw_raw;
  logic             enter;
  logic [VAL_W-1:0] sw_val;
  logic             btn_busy;

  modport master (
    output enter_raw, sw_raw,
    input  enter, sw_val, btn_busy
  );

  modport slave (
    input  enter_raw, sw_raw,
    output enter, sw_val, btn_busy
  );
endinterface

// File: rtl/enter_conditioner.sv
// Synchronises and debounces the ENTER button. Emits one single-cycle 'enter'
// pulse per physical press and latches the switch code on that same edge so
// the datapath sees a value aligned with the FSM transition it triggers.
module enter_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5,
  parameter int VAL_W           = 4
) (
  input  logic                clka,
  input  logic                restart,
  enter_conditioner_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_PRESS   = 2'b01,
    S_HELD    = 2'b10,
    S_RELEASE = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             enter_s1_q, enter_s1_d;
  logic             enter_s_q,  enter_s_d;
  logic [VAL_W-1:0] sw_s1_q,    sw_s1_d;
  logic [VAL_W-1:0] sw_s_q,     sw_s_d;
  state_e           state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic             enter_q,    enter_d;
  logic [VAL_W-1:0] sw_val_q,   sw_val_d;

  // Two-flop synchronisers; nothing downstream touches the raw pins.
  always_comb begin
    enter_s1_d = bus.enter_raw;
    enter_s_d  = enter_s1_q;
    sw_s1_d    = bus.sw_raw;
    sw_s_d     = sw_s1_q;
  end

  // Debounce FSM: cnt tracks consecutive samples that disagree with the
  // debounced level; it saturates at CNT_MAX where the transition happens.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    enter_d  = 1'b0;       // pulse self-clears the edge after it is set
    sw_val_d = sw_val_q;
    case (state_q)
      S_IDLE: begin
        if (enter_s_q) begin
          state_d = S_PRESS;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      S_PRESS: begin
        if (!enter_s_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d  = S_HELD;
          cnt_d    = '0;
          enter_d  = 1'b1;
          sw_val_d = sw_s_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HELD: begin
        // No auto-repeat: a held button just sits here.
        if (!enter_s_q) begin
          state_d = S_RELEASE;
          cnt_d   = CNT_ONE;
        end
      end
      S_RELEASE: begin
        // A bounce back to 1 returns to HELD without a new pulse.
        if (enter_s_q) begin
          state_d = S_HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // All state, including the synchronisers, clears on restart; restart also
  // wins over a pulse that would otherwise fire on the same edge.
  always_ff @(posedge clka) begin
    if (restart) begin
      enter_s1_q <= 1'b0;
      enter_s_q  <= 1'b0;
      sw_s1_q    <= '0;
      sw_s_q     <= '0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      enter_q    <= 1'b0;
      sw_val_q   <= '0;
    end else begin
      enter_s1_q <= enter_s1_d;
      enter_s_q  <= enter_s_d;
      sw_s1_q    <= sw_s1_d;
      sw_s_q     <= sw_s_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      enter_q    <= enter_d;
      sw_val_q   <= sw_val_d;
    end
  end

  assign bus.enter    = enter_q;
  assign bus.sw_val   = sw_val_q;
  assign bus.btn_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_enter_conditioner.sv
// Bench for enter_conditioner with DEBOUNCE_CYCLES=4: scenario table, a few
// hand sequences, then random button/switch activity, all against a
// run-length reference model of the debounced button.
module tb_enter_conditioner;
  localparam int N  = 4;
  localparam int VW = 4;

  logic clka = 1'b0;
  logic restart;
  always #5 clka = ~clka;

  enter_conditioner_if #(.VAL_W(VW)) bus ();

  enter_conditioner #(.DEBOUNCE_CYCLES(N), .CNT_W(5), .VAL_W(VW)) dut (
    .clka    (clka),
    .restart (restart),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  int pcount;

  // Reference model: debounced level plus length of the current run of
  // synced samples disagreeing with it; synced = raw seen two edges ago.
  bit            m_db;
  int            m_run;
  logic          m_enter;
  logic [VW-1:0] m_sw;
  logic          rawq[$];
  logic [VW-1:0] swq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic          s;
    logic [VW-1:0] ss;
    m_enter = 1'b0;
    if (restart) begin
      m_db  = 1'b0;
      m_run = 0;
      m_sw  = '0;
      rawq.delete();
      swq.delete();
    end else begin
      s  = (rawq.size() >= 2) ? rawq[rawq.size()-2] : 1'b0;
      ss = (swq.size()  >= 2) ? swq[swq.size()-2]   : '0;
      rawq.push_back(bus.enter_raw);
      swq.push_back(bus.sw_raw);
      if (rawq.size() > 2) begin
        void'(rawq.pop_front());
        void'(swq.pop_front());
      end
      if (s != m_db) begin
        m_run++;
        if (m_run == N) begin
          m_db  = s;
          m_run = 0;
          if (s) begin
            m_enter = 1'b1;
            m_sw    = ss;
          end
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clka);
    model_edge();
    #1;
    chk("enter",    32'(bus.enter),    32'(m_enter));
    chk("sw_val",   32'(bus.sw_val),   32'(m_sw));
    chk("btn_busy", 32'(bus.btn_busy), 32'(m_db || (m_run != 0)));
    if (bus.enter) pcount++;
  endtask

  typedef struct {
    logic          rst;
    logic          raw;
    logic [VW-1:0] sw;
    int            cyc;
    int            exp_p;
    logic [VW-1:0] exp_sw;
  } seg_t;

  seg_t tbl[$];

  function automatic void add(input logic rst, input logic raw, input logic [VW-1:0] sw,
                              input int cyc, input int exp_p, input logic [VW-1:0] exp_sw);
    seg_t s;
    s.rst = rst; s.raw = raw; s.sw = sw; s.cyc = cyc; s.exp_p = exp_p; s.exp_sw = exp_sw;
    tbl.push_back(s);
  endfunction

  initial begin
    int lat;
    bit got;
    restart       = 1'b1;
    bus.enter_raw = 1'b0;
    bus.sw_raw    = '0;
    m_db = 0; m_run = 0; m_enter = 0; m_sw = '0;

    //   rst raw sw    cyc pulses sw_val
    add(1, 0, 4'h0,  3, 0, 4'h0);   // reset
    add(0, 1, 4'h7, 20, 1, 4'h7);   // clean press
    add(0, 0, 4'h7, 10, 0, 4'h7);
    add(0, 1, 4'h7,  2, 0, 4'h7);   // bounce 1,0,1,0
    add(0, 0, 4'h7,  2, 0, 4'h7);
    add(0, 1, 4'h7,  2, 0, 4'h7);
    add(0, 0, 4'h7,  2, 0, 4'h7);
    add(0, 1, 4'h7, 12, 1, 4'h7);   // final stable rise
    add(0, 0, 4'h7, 10, 0, 4'h7);
    add(0, 1, 4'h3, 10, 1, 4'h3);   // switch change while held
    add(0, 1, 4'h9, 10, 0, 4'h3);
    add(0, 0, 4'h9, 10, 0, 4'h3);
    add(0, 1, 4'h9, 10, 1, 4'h9);
    add(0, 0, 4'h9, 10, 0, 4'h9);
    add(0, 1, 4'h5, 30, 1, 4'h5);   // long hold, release re-bounce
    add(0, 0, 4'h5,  2, 0, 4'h5);
    add(0, 1, 4'h5,  1, 0, 4'h5);
    add(0, 0, 4'h5, 10, 0, 4'h5);
    add(0, 1, 4'h5, 10, 1, 4'h5);
    add(0, 0, 4'h5,  2, 0, 4'h5);   // press during RELEASE
    add(0, 1, 4'h5,  5, 0, 4'h5);
    add(0, 0, 4'h5, 10, 0, 4'h5);
    add(0, 1, 4'h6,  4, 0, 4'h5);   // restart at PRESS cnt=2
    add(1, 1, 4'h6,  2, 0, 4'h0);
    add(0, 1, 4'h6, 10, 1, 4'h6);
    add(1, 1, 4'h6,  3, 0, 4'h0);   // restart mid-hold
    add(0, 0, 4'h6, 10, 0, 4'h0);
    for (int i = 0; i < 8; i++) begin
      add(0, 1, 4'(i + 1), 8, 1, 4'(i + 1));
      add(0, 0, 4'(i + 1), 10, 0, 4'(i + 1));
    end

    for (int i = 0; i < tbl.size(); i++) begin
      restart       = tbl[i].rst;
      bus.enter_raw = tbl[i].raw;
      bus.sw_raw    = tbl[i].sw;
      pcount        = 0;
      repeat (tbl[i].cyc) step();
      chk($sformatf("seg%0d_pulses", i), 32'(pcount), 32'(tbl[i].exp_p));
      chk($sformatf("seg%0d_sw", i), 32'(bus.sw_val), 32'(tbl[i].exp_sw));
      if (i == 0) begin
        chk("rst_enter", 32'(bus.enter),    32'd0);
        chk("rst_busy",  32'(bus.btn_busy), 32'd0);
        chk("rst_sw",    32'(bus.sw_val),   32'd0);
      end
    end

    // Latency from a clean rise to the pulse, then pulse width.
    restart       = 1'b0;
    bus.enter_raw = 1'b0;
    bus.sw_raw    = 4'hc;
    repeat (10) step();
    bus.enter_raw = 1'b1;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      lat++;
      if (bus.enter) got = 1'b1;
    end
    chk("latency", got ? 32'(lat) : 32'hffff_ffff, 32'd6);
    chk("latency_sw", 32'(bus.sw_val), 32'hc);
    step();
    chk("pulse_width", 32'(bus.enter), 32'd0);
    bus.enter_raw = 1'b0;
    repeat (10) step();

    // Random bouncy activity with occasional restarts.
    for (int i = 0; i < 400; i++) begin
      int len;
      restart       = ($urandom_range(0, 39) == 0);
      bus.enter_raw = 1'($urandom_range(0, 1));
      bus.sw_raw    = 4'($urandom);
      len = restart ? int'($urandom_range(1, 2))
                    : (($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 14))
                                                   : int'($urandom_range(1, 5)));
      repeat (len) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
